// File: rtl/me_pe_ctrl.sv
// Control sequencer for the motion-estimation PE array.
// A load FSM streams a current block into one of four PE CB slots while an independent search
// FSM pre-fills the reference array and snake-scans the search window, tagging each candidate.
module me_pe_ctrl #(
  parameter int unsigned PIXEL = 8,
  parameter int unsigned BLK   = 8,
  parameter int unsigned SR_W  = 16,
  parameter int unsigned SR_H  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_start,
  input  logic [1:0]              ld_cb,
  output logic                    ld_ready,
  output logic                    ld_done,
  input  logic                    pix_in_valid,
  input  logic [PIXEL-1:0]        pix_in_data,
  output logic                    pix_in_ready,
  output logic [PIXEL-1:0]        in_curr,
  output logic                    in_curr_enable,
  output logic [1:0]              CB_select,
  input  logic                    srch_start,
  input  logic [1:0]              srch_cb,
  output logic                    srch_ready,
  output logic                    change_ref,
  output logic [1:0]              ref_input_Control,
  output logic [1:0]              abs_Control,
  output logic                    cand_valid,
  output logic [$clog2(SR_W)-1:0] cand_x,
  output logic [$clog2(SR_H)-1:0] cand_y,
  output logic                    srch_done
);

  localparam int unsigned XW   = $clog2(SR_W);
  localparam int unsigned YW   = $clog2(SR_H);
  localparam int unsigned NPIX = BLK * BLK;
  localparam int unsigned LCW  = $clog2(NPIX) + 1;
  localparam int unsigned PCW  = $clog2(BLK) + 1;

  localparam logic [XW-1:0]  XLast   = XW'(SR_W - 1);
  localparam logic [YW-1:0]  YLast   = YW'(SR_H - 1);
  localparam logic [LCW-1:0] LdLast  = LCW'(NPIX - 1);
  localparam logic [PCW-1:0] PreLast = PCW'(BLK - 1);

  // Reference shift sources
  localparam logic [1:0] RefUp1 = 2'b00;
  localparam logic [1:0] RefUp8 = 2'b01;
  localparam logic [1:0] RefDn1 = 2'b10;
  localparam logic [1:0] RefDn8 = 2'b11;

  typedef enum logic [0:0] {LIdle, LLoad} ld_state_e;
  typedef enum logic [1:0] {SIdle, SPre, SScan} s_state_e;

  ld_state_e        ld_state_q, ld_state_d;
  logic [LCW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [1:0]       cb_sel_q, cb_sel_d;
  logic [PIXEL-1:0] in_curr_q, in_curr_d;
  logic             in_curr_en_q, in_curr_en_d;
  logic             ld_done_q, ld_done_d;

  s_state_e         s_state_q, s_state_d;
  logic [PCW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [1:0]       abs_sel_q, abs_sel_d;
  logic             change_ref_q, change_ref_d;
  logic [1:0]       ref_code_q, ref_code_d;

  logic ld_hs, ld_accept, srch_accept, srch_busy, scan_last_q, scan_last_d;

  // Move from a candidate to its snake-order successor
  function automatic logic [1:0] move_code(input logic x_odd, input logic [YW-1:0] y);
    if (!x_odd) return (y == YLast) ? RefDn8 : RefDn1;
    else        return (y == '0)    ? RefUp8 : RefUp1;
  endfunction

  // Handshakes and slot-conflict arbitration; search wins a same-slot tie
  always_comb begin
    srch_busy    = (s_state_q != SIdle);
    pix_in_ready = (ld_state_q == LLoad);
    srch_ready   = (s_state_q == SIdle) && !((ld_state_q == LLoad) && (cb_sel_q == srch_cb));
    srch_accept  = srch_start && srch_ready;
    ld_ready     = (ld_state_q == LIdle) && !(srch_busy && (abs_sel_q == ld_cb)) &&
                   !(srch_accept && (srch_cb == ld_cb));
    ld_accept    = ld_start && ld_ready;
    ld_hs        = pix_in_valid && pix_in_ready;
  end

  // Load FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q   <= LIdle;
      ld_cnt_q     <= '0;
      cb_sel_q     <= '0;
      in_curr_q    <= '0;
      in_curr_en_q <= 1'b0;
      ld_done_q    <= 1'b0;
    end else begin
      ld_state_q   <= ld_state_d;
      ld_cnt_q     <= ld_cnt_d;
      cb_sel_q     <= cb_sel_d;
      in_curr_q    <= in_curr_d;
      in_curr_en_q <= in_curr_en_d;
      ld_done_q    <= ld_done_d;
    end
  end

  // Load FSM next state: count BLK*BLK accepted pixels
  always_comb begin
    ld_state_d = ld_state_q;
    ld_cnt_d   = ld_cnt_q;
    cb_sel_d   = cb_sel_q;
    unique case (ld_state_q)
      LIdle: begin
        if (ld_accept) begin
          ld_state_d = LLoad;
          ld_cnt_d   = '0;
          cb_sel_d   = ld_cb;
        end
      end
      LLoad: begin
        if (ld_hs) begin
          if (ld_cnt_q == LdLast) begin
            ld_state_d = LIdle;
            ld_cnt_d   = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Load outputs: each handshake becomes a PE-chain shift one cycle later
  always_comb begin
    in_curr_d    = ld_hs ? pix_in_data : in_curr_q;
    in_curr_en_d = ld_hs;
    ld_done_d    = ld_hs && (ld_cnt_q == LdLast);
  end

  // Search FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state_q    <= SIdle;
      pre_cnt_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      abs_sel_q    <= '0;
      change_ref_q <= 1'b0;
      ref_code_q   <= RefUp1;
    end else begin
      s_state_q    <= s_state_d;
      pre_cnt_q    <= pre_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      abs_sel_q    <= abs_sel_d;
      change_ref_q <= change_ref_d;
      ref_code_q   <= ref_code_d;
    end
  end

  // Search FSM next state: BLK fill shifts, then snake scan over the window
  always_comb begin
    s_state_d   = s_state_q;
    pre_cnt_d   = pre_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    abs_sel_d   = abs_sel_q;
    scan_last_q = (x_q == XLast) && (y_q == '0);
    unique case (s_state_q)
      SIdle: begin
        if (srch_accept) begin
          s_state_d = SPre;
          pre_cnt_d = '0;
          abs_sel_d = srch_cb;
          x_d       = '0;
          y_d       = '0;
        end
      end
      SPre: begin
        if (pre_cnt_q == PreLast) begin
          s_state_d = SScan;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      SScan: begin
        if (scan_last_q) begin
          s_state_d = SIdle;
          x_d       = '0;
          y_d       = '0;
        end else if (!x_q[0]) begin
          if (y_q == YLast) x_d = x_q + 1'b1;
          else              y_d = y_q + 1'b1;
        end else begin
          if (y_q == '0) x_d = x_q + 1'b1;
          else           y_d = y_q - 1'b1;
        end
      end
      default: s_state_d = SIdle;
    endcase
  end

  // Search outputs, registered from the next state so the shift strobe leads the scan by
  // exactly the candidate it moves away from
  always_comb begin
    change_ref_d = 1'b0;
    ref_code_d   = ref_code_q;
    scan_last_d  = (x_d == XLast) && (y_d == '0);
    unique case (s_state_d)
      SPre: begin
        change_ref_d = 1'b1;
        ref_code_d   = RefDn1;
      end
      SScan: begin
        if (!scan_last_d) begin
          change_ref_d = 1'b1;
          ref_code_d   = move_code(x_d[0], y_d);
        end
      end
      default: ;
    endcase
  end

  assign ld_done           = ld_done_q;
  assign in_curr           = in_curr_q;
  assign in_curr_enable    = in_curr_en_q;
  assign CB_select         = cb_sel_q;
  assign change_ref        = change_ref_q;
  assign ref_input_Control = ref_code_q;
  assign abs_Control       = abs_sel_q;
  assign cand_valid        = (s_state_q == SScan);
  assign cand_x            = x_q;
  assign cand_y            = y_q;
  assign srch_done         = (s_state_q == SScan) && scan_last_q;

endmodule

// File: tb/tb_me_pe_ctrl.sv
// Self-checking bench for me_pe_ctrl: loads, snake search, overlap, arbitration, reset abort.
module tb_me_pe_ctrl;

  localparam int PIXEL = 8;
  localparam int BLK   = 8;
  localparam int SR_W  = 16;
  localparam int SR_H  = 16;
  localparam int XW    = 4;
  localparam int YW    = 4;
  localparam int NPIX  = BLK * BLK;
  localparam int NCAND = SR_W * SR_H;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_start, ld_ready, ld_done;
  logic [1:0]       ld_cb;
  logic             pix_in_valid, pix_in_ready;
  logic [PIXEL-1:0] pix_in_data, in_curr;
  logic             in_curr_enable;
  logic [1:0]       CB_select;
  logic             srch_start, srch_ready, change_ref, cand_valid, srch_done;
  logic [1:0]       srch_cb, ref_input_Control, abs_Control;
  logic [XW-1:0]    cand_x;
  logic [YW-1:0]    cand_y;

  int checks = 0;
  int errors = 0;

  // Load recorder state
  logic [PIXEL-1:0] exp_pix[NPIX];
  logic [PIXEL-1:0] l_obs[$];
  logic             l_acc_ok, l_done_en;
  int               l_done_cnt, l_done_cyc, l_ready_late, l_first_en, l_last_en;

  // Search recorder state
  logic [XW-1:0] obs_cx[NCAND];
  logic [YW-1:0] obs_cy[NCAND];
  logic          obs_cr[NCAND];
  logic [1:0]    obs_code[NCAND];
  logic          s_acc_ok;
  int            s_pre, s_pre_bad, s_n, s_first, s_done_cnt, s_done_at, s_abs_bad;
  int            s_ready_cyc, s_stray;

  // Pending-load recorder state
  bit            p_got;
  int            p_bad;
  logic          p_rdy_end;

  me_pe_ctrl #(.PIXEL(PIXEL), .BLK(BLK), .SR_W(SR_W), .SR_H(SR_H)) dut (
    .clk               (clk),
    .rst               (rst),
    .ld_start          (ld_start),
    .ld_cb             (ld_cb),
    .ld_ready          (ld_ready),
    .ld_done           (ld_done),
    .pix_in_valid      (pix_in_valid),
    .pix_in_data       (pix_in_data),
    .pix_in_ready      (pix_in_ready),
    .in_curr           (in_curr),
    .in_curr_enable    (in_curr_enable),
    .CB_select         (CB_select),
    .srch_start        (srch_start),
    .srch_cb           (srch_cb),
    .srch_ready        (srch_ready),
    .change_ref        (change_ref),
    .ref_input_Control (ref_input_Control),
    .abs_Control       (abs_Control),
    .cand_valid        (cand_valid),
    .cand_x            (cand_x),
    .cand_y            (cand_y),
    .srch_done         (srch_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Snake order: column-major, even columns walk y upward, odd columns downward
  function automatic void model_cand(input int i, output int x, output int y);
    x = i / SR_H;
    y = (x % 2 == 0) ? (i % SR_H) : (SR_H - 1 - (i % SR_H));
  endfunction

  // Shift code needed to go from candidate i to candidate i+1
  function automatic int model_move(input int i);
    int x0, y0, x1, y1;
    model_cand(i, x0, y0);
    model_cand(i + 1, x1, y1);
    if (x1 != x0) return (x0 % 2 == 0) ? 3 : 1;
    return (y1 > y0) ? 2 : 0;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    ld_start = 1'b0; ld_cb = '0; pix_in_valid = 1'b0; pix_in_data = '0;
    srch_start = 1'b0; srch_cb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_load(input logic [1:0] slot, input bit stall);
    int c, sent, idle;
    l_obs.delete();
    l_done_cnt = 0; l_done_cyc = -1; l_done_en = 1'b0; l_ready_late = 0;
    l_first_en = -1; l_last_en = -1;
    ld_start = 1'b1; ld_cb = slot;
    #1 l_acc_ok = ld_ready;
    @(posedge clk); #1;
    ld_start = 1'b0;
    c = 1; sent = 0; idle = 0;
    while (c < 1000 && idle < 3) begin
      if (in_curr_enable === 1'b1) begin
        l_obs.push_back(in_curr);
        if (l_first_en < 0) l_first_en = c;
        l_last_en = c;
      end
      if (ld_done === 1'b1) begin
        l_done_cnt++; l_done_cyc = c; l_done_en = in_curr_enable;
      end
      if (sent == NPIX) begin
        idle++;
        if (pix_in_ready !== 1'b0) l_ready_late++;
      end
      pix_in_valid = (sent < NPIX) && (!stall || (c % 2 == 0));
      pix_in_data  = (sent < NPIX) ? exp_pix[sent] : PIXEL'($urandom);
      #1;
      if (pix_in_valid && pix_in_ready) sent++;
      @(posedge clk); #1;
      c++;
    end
    pix_in_valid = 1'b0;
  endtask

  task automatic capture_search(input logic [1:0] slot);
    int c;
    s_pre = 0; s_pre_bad = 0; s_n = 0; s_first = -1; s_done_cnt = 0; s_done_at = -1;
    s_abs_bad = 0; s_ready_cyc = -1; s_stray = 0;
    srch_start = 1'b1; srch_cb = slot;
    #1 s_acc_ok = srch_ready;
    @(posedge clk); #1;
    srch_start = 1'b0;
    c = 1;
    while (c < 1000) begin
      if (cand_valid === 1'b1) begin
        if (s_n < NCAND) begin
          obs_cx[s_n] = cand_x; obs_cy[s_n] = cand_y;
          obs_cr[s_n] = change_ref; obs_code[s_n] = ref_input_Control;
        end
        if (s_first < 0) s_first = c;
        s_n++;
      end else if (change_ref === 1'b1) begin
        if (s_n == 0) begin
          s_pre++;
          if (ref_input_Control !== 2'b10) s_pre_bad++;
        end else s_stray++;
      end
      if (srch_done === 1'b1) begin s_done_cnt++; s_done_at = s_n; end
      if (abs_Control !== slot) s_abs_bad++;
      if (srch_ready === 1'b1) begin s_ready_cyc = c; break; end
      @(posedge clk); #1;
      c++;
    end
  endtask

  // Hold a load request until the search FSM frees up, then withdraw it
  task automatic hold_pending_load(input logic [1:0] slot);
    int n;
    p_got = 0; p_bad = 0; p_rdy_end = 1'b0;
    ld_start = 1'b1; ld_cb = slot;
    n = 0;
    while (n < 1000) begin
      #1;
      if (srch_ready === 1'b1) begin p_got = 1; p_rdy_end = ld_ready; break; end
      if (ld_ready !== 1'b0) p_bad++;
      @(posedge clk); #1;
      n++;
    end
    ld_start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ld_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
    checks++; if (srch_ready !== 1'b1) begin errors++;
      $display("FAIL reset_srch_ready: got %b expected 1", srch_ready); end
    checks++; if (pix_in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_pix_in_ready: got %b expected 0", pix_in_ready); end
    checks++; if ({ld_done, in_curr_enable, change_ref, cand_valid, srch_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {ld_done, in_curr_enable, change_ref, cand_valid, srch_done}); end
    checks++; if ({in_curr, CB_select, ref_input_Control, abs_Control, cand_x, cand_y} !== '0)
    begin
      errors++;
      $display("FAIL reset_values: got %h expected 0",
               {in_curr, CB_select, ref_input_Control, abs_Control, cand_x, cand_y}); end
  endtask

  task automatic test_basic_load();
    apply_reset();
    for (int i = 0; i < NPIX; i++) exp_pix[i] = PIXEL'(i);
    drive_load(2'd2, 1'b0);
    checks++; if (l_acc_ok !== 1'b1) begin errors++;
      $display("FAIL basic_accept: got %b expected 1", l_acc_ok); end
    checks++; if (CB_select !== 2'd2) begin errors++;
      $display("FAIL basic_cb_select: got %0d expected 2", CB_select); end
    checks++; if (l_obs.size() != NPIX) begin errors++;
      $display("FAIL basic_count: got %0d expected %0d", l_obs.size(), NPIX); end
    for (int i = 0; i < l_obs.size() && i < NPIX; i++) begin
      checks++; if (l_obs[i] !== exp_pix[i]) begin errors++;
        $display("FAIL basic_pixel[%0d]: got %0d expected %0d", i, l_obs[i], exp_pix[i]); end
    end
    checks++; if (l_first_en != 2 || l_last_en != NPIX + 1) begin errors++;
      $display("FAIL basic_enable_window: got %0d..%0d expected 2..%0d",
               l_first_en, l_last_en, NPIX + 1); end
    checks++; if (l_done_cnt != 1 || l_done_cyc != NPIX + 1) begin errors++;
      $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d",
               l_done_cnt, l_done_cyc, NPIX + 1); end
    checks++; if (l_done_en !== 1'b1) begin errors++;
      $display("FAIL basic_done_with_enable: got %b expected 1", l_done_en); end
    checks++; if (l_ready_late != 0) begin errors++;
      $display("FAIL basic_ready_after: got %0d cycles high expected 0", l_ready_late); end
  endtask

  task automatic test_stalled_load();
    logic [1:0] slot;
    apply_reset();
    slot = 2'($urandom_range(0, 3));
    for (int i = 0; i < NPIX; i++) exp_pix[i] = PIXEL'($urandom);
    drive_load(slot, 1'b1);
    checks++; if (CB_select !== slot) begin errors++;
      $display("FAIL stall_cb_select: got %0d expected %0d", CB_select, slot); end
    checks++; if (l_obs.size() != NPIX) begin errors++;
      $display("FAIL stall_count: got %0d expected %0d", l_obs.size(), NPIX); end
    for (int i = 0; i < l_obs.size() && i < NPIX; i++) begin
      checks++; if (l_obs[i] !== exp_pix[i]) begin errors++;
        $display("FAIL stall_pixel[%0d]: got %0d expected %0d", i, l_obs[i], exp_pix[i]); end
    end
    checks++; if (l_done_cnt != 1 || l_done_cyc != 2 * NPIX + 1 || l_done_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got %0d pulses at %0d en %b expected 1 at %0d en 1",
               l_done_cnt, l_done_cyc, l_done_en, 2 * NPIX + 1); end
  endtask

  task automatic test_search();
    int ex, ey;
    apply_reset();
    capture_search(2'd1);
    checks++; if (s_acc_ok !== 1'b1) begin errors++;
      $display("FAIL search_accept: got %b expected 1", s_acc_ok); end
    checks++; if (s_pre != BLK || s_pre_bad != 0) begin errors++;
      $display("FAIL search_pre: got %0d strobes (%0d bad code) expected %0d",
               s_pre, s_pre_bad, BLK); end
    checks++; if (s_first != BLK + 1) begin errors++;
      $display("FAIL search_first_cand: got %0d expected %0d", s_first, BLK + 1); end
    checks++; if (s_n != NCAND) begin errors++;
      $display("FAIL search_cand_count: got %0d expected %0d", s_n, NCAND); end
    for (int i = 0; i < s_n && i < NCAND; i++) begin
      model_cand(i, ex, ey);
      checks++; if (obs_cx[i] !== XW'(ex) || obs_cy[i] !== YW'(ey)) begin errors++;
        $display("FAIL search_cand[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                 i, obs_cx[i], obs_cy[i], ex, ey); end
      if (i < NCAND - 1) begin
        checks++; if (obs_cr[i] !== 1'b1 || obs_code[i] !== 2'(model_move(i))) begin errors++;
          $display("FAIL search_move[%0d]: got cr %b code %0d expected cr 1 code %0d",
                   i, obs_cr[i], obs_code[i], model_move(i)); end
      end else begin
        checks++; if (obs_cr[i] !== 1'b0) begin errors++;
          $display("FAIL search_last_no_move: got %b expected 0", obs_cr[i]); end
      end
    end
    checks++; if (obs_code[15] !== 2'b11 || obs_code[31] !== 2'b01) begin errors++;
      $display("FAIL search_column_moves: got %0d,%0d expected 3,1",
               obs_code[15], obs_code[31]); end
    checks++; if (s_stray != 0) begin errors++;
      $display("FAIL search_stray_change_ref: got %0d expected 0", s_stray); end
    checks++; if (s_done_cnt != 1 || s_done_at != NCAND) begin errors++;
      $display("FAIL search_done: got %0d pulses at cand %0d expected 1 at %0d",
               s_done_cnt, s_done_at, NCAND); end
    checks++; if (s_ready_cyc != BLK + NCAND + 1) begin errors++;
      $display("FAIL search_ready_return: got %0d expected %0d", s_ready_cyc, BLK + NCAND + 1); end
    checks++; if (s_abs_bad != 0) begin errors++;
      $display("FAIL search_abs_control: got %0d bad cycles expected 0", s_abs_bad); end
  endtask

  task automatic test_overlap();
    int bad;
    apply_reset();
    for (int i = 0; i < NPIX; i++) exp_pix[i] = PIXEL'($urandom);
    fork
      capture_search(2'd1);
      begin
        drive_load(2'd3, 1'b1);
        hold_pending_load(2'd1);
      end
    join
    checks++; if (l_acc_ok !== 1'b1 || CB_select !== 2'd3) begin errors++;
      $display("FAIL overlap_load_accept: got acc %b slot %0d expected acc 1 slot 3",
               l_acc_ok, CB_select); end
    bad = 0;
    for (int i = 0; i < l_obs.size() && i < NPIX; i++) if (l_obs[i] !== exp_pix[i]) bad++;
    checks++; if (l_obs.size() != NPIX || bad != 0 || l_done_cnt != 1) begin errors++;
      $display("FAIL overlap_load_data: got %0d pixels %0d wrong %0d done expected %0d 0 1",
               l_obs.size(), bad, l_done_cnt, NPIX); end
    checks++; if (s_acc_ok !== 1'b1 || s_n != NCAND || s_done_cnt != 1) begin errors++;
      $display("FAIL overlap_search: got acc %b %0d cands %0d done expected 1 %0d 1",
               s_acc_ok, s_n, s_done_cnt, NCAND); end
    checks++; if (s_ready_cyc != BLK + NCAND + 1) begin errors++;
      $display("FAIL overlap_search_len: got %0d expected %0d", s_ready_cyc, BLK + NCAND + 1); end
    checks++; if (p_got != 1 || p_bad != 0) begin errors++;
      $display("FAIL overlap_conflict_block: got seen %0d early-ready %0d expected 1 0",
               p_got, p_bad); end
    checks++; if (p_rdy_end !== 1'b1) begin errors++;
      $display("FAIL overlap_ready_after_search: got %b expected 1", p_rdy_end); end
    drive_load(2'd1, 1'b0);
    checks++; if (l_acc_ok !== 1'b1 || l_obs.size() != NPIX || CB_select !== 2'd1) begin
      errors++;
      $display("FAIL overlap_late_load: got acc %b %0d pixels slot %0d expected 1 %0d 1",
               l_acc_ok, l_obs.size(), CB_select, NPIX); end
  endtask

  task automatic test_same_slot();
    logic acc_rdy;
    apply_reset();
    for (int i = 0; i < NPIX; i++) exp_pix[i] = PIXEL'($urandom);
    fork
      capture_search(2'd0);
      begin
        ld_start = 1'b1; ld_cb = 2'd0;
        #1 acc_rdy = ld_ready;
        @(posedge clk); #1;
        hold_pending_load(2'd0);
      end
    join
    checks++; if (acc_rdy !== 1'b0 || s_acc_ok !== 1'b1) begin errors++;
      $display("FAIL same_slot_arbitration: got ld_ready %b srch_ready %b expected 0 1",
               acc_rdy, s_acc_ok); end
    checks++; if (s_n != NCAND || s_done_cnt != 1) begin errors++;
      $display("FAIL same_slot_search: got %0d cands %0d done expected %0d 1",
               s_n, s_done_cnt, NCAND); end
    checks++; if (p_got != 1 || p_bad != 0 || p_rdy_end !== 1'b1) begin errors++;
      $display("FAIL same_slot_pending: got seen %0d early %0d end %b expected 1 0 1",
               p_got, p_bad, p_rdy_end); end
    drive_load(2'd0, 1'b0);
    checks++; if (l_acc_ok !== 1'b1 || l_obs.size() != NPIX || l_done_cnt != 1) begin errors++;
      $display("FAIL same_slot_load_after: got acc %b %0d pixels %0d done expected 1 %0d 1",
               l_acc_ok, l_obs.size(), l_done_cnt, NPIX); end
  endtask

  task automatic test_reset_mid_search();
    int c, n, ex, ey, done_seen, late_bad;
    bit hit;
    apply_reset();
    srch_start = 1'b1; srch_cb = 2'($urandom_range(1, 3));
    @(posedge clk); #1;
    srch_start = 1'b0;
    c = 0; n = 0; done_seen = 0; hit = 0;
    while (c < 1000) begin
      if (srch_done === 1'b1) done_seen++;
      if (cand_valid === 1'b1) begin
        if (n == 100) begin hit = 1; break; end
        n++;
      end
      @(posedge clk); #1;
      c++;
    end
    model_cand(100, ex, ey);
    checks++; if (hit != 1 || cand_x !== XW'(ex) || cand_y !== YW'(ey) || change_ref !== 1'b1)
    begin
      errors++;
      $display("FAIL abort_cand100: got hit %0d (%0d,%0d) cr %b expected 1 (%0d,%0d) cr 1",
               hit, cand_x, cand_y, change_ref, ex, ey); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (change_ref !== 1'b0 || cand_valid !== 1'b0 || srch_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobes: got cr %b cv %b done %b expected 0 0 0",
               change_ref, cand_valid, srch_done); end
    checks++; if (srch_ready !== 1'b1 || abs_Control !== 2'd0 || ref_input_Control !== 2'd0)
    begin
      errors++;
      $display("FAIL abort_state: got ready %b abs %0d ref %0d expected 1 0 0",
               srch_ready, abs_Control, ref_input_Control); end
    late_bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (cand_valid !== 1'b0 || change_ref !== 1'b0 || srch_done !== 1'b0) late_bad++;
    end
    checks++; if (done_seen != 0 || late_bad != 0) begin errors++;
      $display("FAIL abort_no_done: got %0d done %0d late strobes expected 0 0",
               done_seen, late_bad); end
  endtask

  initial begin
    rst = 1'b1;
    ld_start = 1'b0; ld_cb = '0; pix_in_valid = 1'b0; pix_in_data = '0;
    srch_start = 1'b0; srch_cb = '0;
    test_reset();
    test_basic_load();
    test_stalled_load();
    test_search();
    test_overlap();
    test_same_slot();
    test_reset_mid_search();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/me_pe_ctrl.md
# me_pe_ctrl

Sequencer that drives the control side of the motion-estimation PE array. It streams a current block (CB) into one of the four per-PE CB slots and runs a snake-scan over the reference search window. The scan steers the reference shift direction and selects the slot being compared, and it tags each cycle whose PE absolute differences are valid with the candidate motion vector. It sits between the CB/ref-window fetch logic and the PE array, and feeds candidate tags to the downstream SAD adder tree.

## Interface
Parameters:
- PIXEL, 8, pixel width in bits
- BLK, 8, CB edge; CB holds BLK*BLK pixels; array has BLK ref rows to fill
- SR_W, 16, candidate columns in the search window (>=2, even)
- SR_H, 16, candidate rows in the search window (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ld_start  in  1  request to load a CB; accepted when ld_start && ld_ready
- ld_cb  in  2  target slot, sampled at accept
- ld_ready  out  1  load FSM idle and slot not in conflict
- ld_done  out  1  one-cycle pulse with the last in_curr_enable
- pix_in_valid  in  1  upstream CB pixel valid
- pix_in_data  in  PIXEL  CB pixel, raster order
- pix_in_ready  out  1  high only in LOAD
- in_curr  out  PIXEL  pixel into the head of the PE chain (registered)
- in_curr_enable  out  1  shift strobe for the PE chain (registered)
- CB_select  out  2  slot written/forwarded by the PE chain
- srch_start  in  1  request to search; accepted when srch_start && srch_ready
- srch_cb  in  2  slot to compare, sampled at accept
- srch_ready  out  1  search FSM idle and slot not in conflict
- change_ref  out  1  reference shift strobe (registered)
- ref_input_Control  out  2  shift source: 00 up_adj_1, 01 up_adj_8, 10 down_adj_1, 11 down_adj_8
- abs_Control  out  2  slot compared against ref
- cand_valid  out  1  PE abs outputs valid for (cand_x, cand_y)
- cand_x  out  $clog2(SR_W)  candidate column
- cand_y  out  $clog2(SR_H)  candidate row
- srch_done  out  1  one-cycle pulse with the last cand_valid

## Operation
- The load FSM and the search FSM are independent. A CB can be loaded into one slot while another slot is searched (prefetch).
- Load FSM, L_IDLE -> L_LOAD:
  - At accept, latch ld_cb into CB_select. CB_select holds that value after the load until the next accept.
  - In L_LOAD, each pix_in_valid && pix_in_ready handshake produces in_curr = data and in_curr_enable = 1 on the next cycle. A cycle without a handshake produces in_curr_enable = 0 and in_curr holds its value.
  - After BLK*BLK handshakes, return to L_IDLE. ld_done coincides with the final in_curr_enable.
- Search FSM, S_IDLE -> S_PRE -> S_SCAN -> S_IDLE:
  - At accept, latch srch_cb into abs_Control; it holds after the search.
  - S_PRE lasts BLK cycles: change_ref = 1 with code 10 (fills the array).
  - S_SCAN steps through SR_W*SR_H candidates in snake order:
    - Column x even: y runs 0..SR_H-1, vertical move code 10.
    - Column x odd: y runs SR_H-1..0, vertical move code 00.
    - At a column end, the move is horizontal: code 11 after an even column, 01 after an odd column.
  - Each S_SCAN cycle asserts cand_valid for the current candidate. In the same cycle it issues change_ref for the move to the next candidate, except on the final candidate.
- Conflict rules:
  - ld_ready = L_IDLE && !(search active on ld_cb) && !(srch_start && srch_ready && srch_cb == ld_cb).
  - srch_ready = S_IDLE && !(L_LOAD on srch_cb).
  - When both starts target the same slot in the same cycle, search wins.
- When change_ref = 0, ref_input_Control holds its last value.

## Timing
- Reset: all outputs 0 except ld_ready = 1 and srch_ready = 1. Both FSMs go idle and all counters clear.
- Reset mid-operation aborts immediately. No ld_done or srch_done is issued, and strobes are 0 on the following cycle.
- Load: accept at cycle T. pix_in_ready = 1 from T+1 until the cycle of the last handshake. Handshake at cycle k gives in_curr_enable at k+1. With no stalls, ld_done is at T+1+BLK*BLK.
- Search: accept at cycle T.
  - change_ref (PRE) at T+1..T+BLK.
  - cand (0,0) valid at T+BLK+1.
  - cand_valid is continuous for SR_W*SR_H cycles; the last is at T+BLK+SR_W*SR_H, with srch_done in the same cycle.
  - change_ref is high at T+BLK+1..T+BLK+SR_W*SR_H-1.
  - srch_ready returns high at T+BLK+SR_W*SR_H+1.
- Ref-window memory must present edge data in the same cycle that change_ref/ref_input_Control are high.
- Final candidate: (SR_W-1, 0), since SR_W is even.
- Counters:
  - x uses $clog2(SR_W) bits.
  - y uses $clog2(SR_H) bits and saturates at its end value rather than wrapping.
  - The load counter uses $clog2(BLK*BLK)+1 bits.

## Test plan
- Basic load: reset, ld_start with ld_cb=2, 64 pixels 0..63 with no stalls -> CB_select=2, in_curr_enable high for 64 consecutive cycles carrying 0..63, ld_done on the 64th, pix_in_ready low afterwards.
- Stalled load: pix_in_valid toggled every other cycle -> exactly 64 in_curr_enable pulses, values in order, ld_done with the last.
- Search with defaults, srch_cb=1:
  - 8 PRE strobes with code 10.
  - 256 consecutive cand_valid.
  - Sequence (0,0)..(0,15), (1,15)..(1,0), ...
  - Code 11 between columns 0/1, code 01 between columns 1/2.
  - srch_done with (15,0); abs_Control=1 throughout.
- Overlap: load slot 3 while searching slot 1 -> both complete. ld_start on slot 1 during that search -> ld_ready=0 until srch_ready returns.
- Same-cycle ld_start/srch_start on slot 0, both idle -> search accepted, load stays pending until search ends.
- Reset mid-search at candidate 100 -> next cycle change_ref=0 and cand_valid=0, no srch_done, srch_ready=1.
